// File: rtl/range_image_builder.sv
// Range-image scatter stage: min-range z-buffer via read-modify-write on one BRAM port.
// Clears the image, accepts a frame, then holds it for the downstream drain.
module range_image_builder #(
  parameter int COLS    = 2048,
  parameter int ROWS    = 128,
  parameter int RANGE_W = 16,
  parameter int ADDR_W  = 19
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_point_valid,
  output logic               o_point_ready,
  input  logic [15:0]        i_col,
  input  logic [7:0]         i_row,
  input  logic [RANGE_W-1:0] i_range,
  input  logic               i_frame_last,
  output logic [ADDR_W-1:0]  bram_addr,
  output logic               bram_we,
  output logic [RANGE_W-1:0] bram_wdata,
  input  logic [RANGE_W-1:0] bram_rdata,
  output logic               o_allpoints,
  input  logic               i_drain_done,
  output logic [31:0]        o_points_written,
  output logic [31:0]        o_points_dropped
);

  localparam int CB = $clog2(COLS);
  localparam int RB = $clog2(ROWS);
  localparam logic [31:0] COLS_U = 32'(COLS);
  localparam logic [31:0] ROWS_U = 32'(ROWS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROWS * COLS - 1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_ACCEPT,
    S_READ,
    S_CMP,
    S_WRITE,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [RANGE_W-1:0] range_q, range_n;
  logic               last_q, last_n;
  logic [ADDR_W-1:0]  addr_n;
  logic               we_n;
  logic [RANGE_W-1:0] wdata_n;
  logic [31:0]        wr_n, dr_n;
  logic               bad, take;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  assign o_point_ready = (state == S_ACCEPT);
  assign o_allpoints   = (state == S_DONE);

  assign bad = (32'(i_col) >= COLS_U) ||
               (32'(i_row) >= ROWS_U) ||
               (i_range == '0);

  // Empty pixel (0) always loses; ties keep the stored return.
  assign take = (bram_rdata == '0) || (range_q < bram_rdata);

  always_comb begin
    state_n = state;
    addr_n  = bram_addr;
    we_n    = 1'b0;
    wdata_n = bram_wdata;
    range_n = range_q;
    last_n  = last_q;
    wr_n    = o_points_written;
    dr_n    = o_points_dropped;
    unique case (state)
      S_CLEAR: begin
        wdata_n = '0;
        if (bram_we && bram_addr == LAST) begin
          state_n = S_ACCEPT;
          wr_n    = '0;
          dr_n    = '0;
        end else begin
          we_n   = 1'b1;
          addr_n = bram_we ? bram_addr + ADDR_W'(1) : '0;
        end
      end
      S_ACCEPT: begin
        if (i_point_valid) begin
          range_n = i_range;
          last_n  = i_frame_last;
          if (bad) begin
            dr_n    = sat_inc(o_points_dropped);
            state_n = i_frame_last ? S_DONE : S_ACCEPT;
          end else begin
            addr_n  = ADDR_W'({i_row[RB-1:0], i_col[CB-1:0]});
            state_n = S_READ;
          end
        end
      end
      S_READ: begin
        state_n = S_CMP;
      end
      S_CMP: begin
        if (take) begin
          we_n    = 1'b1;
          wdata_n = range_q;
          wr_n    = sat_inc(o_points_written);
          state_n = S_WRITE;
        end else begin
          dr_n    = sat_inc(o_points_dropped);
          state_n = last_q ? S_DONE : S_ACCEPT;
        end
      end
      S_WRITE: begin
        state_n = last_q ? S_DONE : S_ACCEPT;
      end
      S_DONE: begin
        if (i_drain_done) begin
          state_n = S_CLEAR;
          we_n    = 1'b1;
          addr_n  = '0;
          wdata_n = '0;
        end
      end
      default: begin
        state_n = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= S_CLEAR;
      bram_addr        <= '0;
      bram_we          <= 1'b0;
      bram_wdata       <= '0;
      range_q          <= '0;
      last_q           <= 1'b0;
      o_points_written <= '0;
      o_points_dropped <= '0;
    end else begin
      state            <= state_n;
      bram_addr        <= addr_n;
      bram_we          <= we_n;
      bram_wdata       <= wdata_n;
      range_q          <= range_n;
      last_q           <= last_n;
      o_points_written <= wr_n;
      o_points_dropped <= dr_n;
    end
  end

endmodule

// File: tb/tb_range_image_builder.sv
// Directed bench for range_image_builder on an 8x4 image with a BRAM model.
// Vector table for single points, hand sequences for clear, drain and reset.
module tb_range_image_builder;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_point_valid = 1'b0;
  logic        o_point_ready;
  logic [15:0] i_col = '0;
  logic [7:0]  i_row = '0;
  logic [15:0] i_range = '0;
  logic        i_frame_last = 1'b0;
  logic [4:0]  bram_addr;
  logic        bram_we;
  logic [15:0] bram_wdata;
  logic [15:0] bram_rdata;
  logic        o_allpoints;
  logic        i_drain_done = 1'b0;
  logic [31:0] o_points_written;
  logic [31:0] o_points_dropped;

  range_image_builder #(
    .COLS(8), .ROWS(4), .RANGE_W(16), .ADDR_W(5)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_point_valid(i_point_valid), .o_point_ready(o_point_ready),
    .i_col(i_col), .i_row(i_row), .i_range(i_range),
    .i_frame_last(i_frame_last),
    .bram_addr(bram_addr), .bram_we(bram_we),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .o_allpoints(o_allpoints), .i_drain_done(i_drain_done),
    .o_points_written(o_points_written),
    .o_points_dropped(o_points_dropped)
  );

  always #5 i_clk = ~i_clk;

  logic [15:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'hA5A5;
    bram_rdata = '0;
  end

  always @(posedge i_clk) begin
    if (bram_we) mem[bram_addr] <= bram_wdata;
    bram_rdata <= mem[bram_addr];
  end

  int          wr_cnt = 0;
  int          nz_cnt = 0;
  logic [4:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  always @(posedge i_clk) begin
    if (bram_we) begin
      wr_cnt++;
      wr_addr = bram_addr;
      wr_data = bram_wdata;
      if (bram_wdata != 16'd0) nz_cnt++;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_clear(input string tag);
    int  n;
    bit  ok;
    n = 0;
    while (!bram_we && n < 5) begin
      step();
      n++;
    end
    ok = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (!bram_we || bram_addr != 5'(k) || bram_wdata != 16'd0 ||
          o_point_ready)
        ok = 1'b0;
      step();
    end
    chk({tag, "_clear_seq"}, 32'(ok), 32'd1);
    chk({tag, "_ready_after"}, 32'(o_point_ready), 32'd1);
    chk({tag, "_we_off"}, 32'(bram_we), 32'd0);
    chk({tag, "_written0"}, o_points_written, 32'd0);
    chk({tag, "_dropped0"}, o_points_dropped, 32'd0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!o_point_ready && n < 10) begin
      step();
      n++;
    end
    chk("ready_wait", 32'(o_point_ready), 32'd1);
  endtask

  typedef struct {
    logic [15:0] col;
    logic [7:0]  row;
    logic [15:0] rng;
    logic        last;
    int          lat;
    logic        wr;
    logic [4:0]  waddr;
    logic [15:0] wdat;
    int          nw;
    int          nd;
  } vec_t;

  vec_t tv [8];

  initial begin
    int base, n, nz0;
    tv[0] = '{16'd3, 8'd2, 16'd500, 1'b0, 3, 1'b1, 5'd19, 16'd500, 1, 0};
    tv[1] = '{16'd3, 8'd2, 16'd700, 1'b0, 2, 1'b0, 5'd0,  16'd0,   1, 1};
    tv[2] = '{16'd3, 8'd2, 16'd200, 1'b0, 3, 1'b1, 5'd19, 16'd200, 2, 1};
    tv[3] = '{16'd3, 8'd2, 16'd200, 1'b0, 2, 1'b0, 5'd0,  16'd0,   2, 2};
    tv[4] = '{16'd8, 8'd0, 16'd50,  1'b0, 0, 1'b0, 5'd0,  16'd0,   2, 3};
    tv[5] = '{16'd0, 8'd4, 16'd50,  1'b0, 0, 1'b0, 5'd0,  16'd0,   2, 4};
    tv[6] = '{16'd1, 8'd1, 16'd0,   1'b0, 0, 1'b0, 5'd0,  16'd0,   2, 5};
    tv[7] = '{16'd7, 8'd3, 16'd9,   1'b1, 3, 1'b1, 5'd31, 16'd9,   3, 5};

    step();
    step();
    chk("rst_ready", 32'(o_point_ready), 32'd0);
    chk("rst_we", 32'(bram_we), 32'd0);
    chk("rst_addr", 32'(bram_addr), 32'd0);
    chk("rst_wdata", 32'(bram_wdata), 32'd0);
    chk("rst_allpoints", 32'(o_allpoints), 32'd0);
    chk("rst_written", o_points_written, 32'd0);
    chk("rst_dropped", o_points_dropped, 32'd0);
    i_rst = 1'b0;
    check_clear("init");

    i_drain_done = 1'b1;
    step();
    i_drain_done = 1'b0;
    chk("stray_drain_ready", 32'(o_point_ready), 32'd1);
    chk("stray_drain_allpts", 32'(o_allpoints), 32'd0);

    for (int v = 0; v < 8; v++) begin
      wait_ready();
      base = wr_cnt;
      i_col = tv[v].col;
      i_row = tv[v].row;
      i_range = tv[v].rng;
      i_frame_last = tv[v].last;
      i_point_valid = 1'b1;
      step();
      i_point_valid = 1'b0;
      i_frame_last = 1'b0;
      n = 0;
      while (!(o_point_ready || o_allpoints) && n < 20) begin
        step();
        n++;
      end
      chk($sformatf("v%0d_latency", v), 32'(n), 32'(tv[v].lat));
      chk($sformatf("v%0d_writes", v), 32'(wr_cnt - base),
          tv[v].wr ? 32'd1 : 32'd0);
      if (tv[v].wr) begin
        chk($sformatf("v%0d_waddr", v), 32'(wr_addr), 32'(tv[v].waddr));
        chk($sformatf("v%0d_wdata", v), 32'(wr_data), 32'(tv[v].wdat));
      end
      chk($sformatf("v%0d_written", v), o_points_written, 32'(tv[v].nw));
      chk($sformatf("v%0d_dropped", v), o_points_dropped, 32'(tv[v].nd));
      chk($sformatf("v%0d_allpoints", v), 32'(o_allpoints),
          32'(tv[v].last));
    end

    for (int k = 0; k < 3; k++) step();
    chk("done_hold_allpts", 32'(o_allpoints), 32'd1);
    chk("done_hold_ready", 32'(o_point_ready), 32'd0);
    chk("done_hold_written", o_points_written, 32'd3);
    chk("done_hold_dropped", o_points_dropped, 32'd5);

    i_drain_done = 1'b1;
    step();
    i_drain_done = 1'b0;
    chk("drain_allpts_low", 32'(o_allpoints), 32'd0);
    chk("drain_clear_start", 32'(bram_addr), 32'd0);
    check_clear("drain");
    chk("mem19_cleared", 32'(mem[19]), 32'd0);
    chk("mem31_cleared", 32'(mem[31]), 32'd0);

    wait_ready();
    i_col = 16'd2;
    i_row = 8'd1;
    i_range = 16'd77;
    i_point_valid = 1'b1;
    step();
    i_point_valid = 1'b0;
    chk("rmw_read_addr", 32'(bram_addr), 32'd10);
    chk("rmw_ready_low", 32'(o_point_ready), 32'd0);
    nz0 = nz_cnt;
    i_rst = 1'b1;
    step();
    chk("midrst_we", 32'(bram_we), 32'd0);
    chk("midrst_addr", 32'(bram_addr), 32'd0);
    chk("midrst_ready", 32'(o_point_ready), 32'd0);
    step();
    i_rst = 1'b0;
    check_clear("midrst");
    chk("midrst_no_write", 32'(nz_cnt - nz0), 32'd0);
    chk("midrst_mem10", 32'(mem[10]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
